multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle control decoder. It sequences FETCH/DECODE/EXEC/MEM/WB
//  for data-processing, load/store and branch instructions, and evaluates all 16 ARM condition
//  codes against an internal NZCV register. It waits on a memory ready handshake with a
//  programmable timeout. It drives the datapath muxes, write strobes and ALU op code.
// PARAMETERS
//  OPCODE_W  6   width of funct field: [5]=I (imm operand B), [4:1]=cmd, [0]=S (DP) / L (mem) ; [4]=link (branch)
//  ALUOP_W   4   width of opALU (cmd passes through, zero-extended/truncated to ALUOP_W)
//  MAX_WAIT  15  cycles to wait for mem_ready before bus_err; 0 = wait forever
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  condicion  in   4         instruction cond field (valid from DECODE on, held by external IR)
//  operation  in   2         00 DP, 01 mem, 10 branch, 11 undefined (treated as NOP)
//  opcodes    in   OPCODE_W  instruction funct field
//  alu_flags  in   4         ALU NZCV result of current EXEC operation
//  mem_ready  in   1         memory completed request this cycle
//  ir_wr      out  1         latch instruction into IR
//  pc_wr      out  1         PC write strobe
//  selPC      out  1         0 = PC+4, 1 = branch target
//  regWr      out  1         register-file write strobe
//  selAddWr   out  1         1 = write address R14 (BL), 0 = Rd
//  opALU      out  ALUOP_W   ALU operation
//  cin        out  1         ALU carry-in
//  selOperaB  out  1         1 = immediate/offset, 0 = register operand B
//  selDiWr    out  2         write data: 00 ALU, 01 mem rdata, 10 PC+4
//  memWr      out  1         data-memory write (valid with mem_req)
//  mem_req    out  1         memory request (instr in FETCH, data in MEM)
//  flags      out  4         NZCV register
//  bus_err    out  1         one-cycle pulse on memory timeout
// BEHAVIOUR
//  - Reset: state=FETCH, flags=0000, wait counter=0. All outputs are 0 in any cycle with rst=1.
//    mem_req rises in the first cycle after rst deasserts. Reset mid-instruction aborts it,
//    so no strobe is asserted in the reset cycle.
//  - Outputs are decoded from the registered state and the current fields. Strobes are single-cycle.
//  - FETCH: mem_req=1. On mem_ready: ir_wr=1, pc_wr=1, selPC=0 -> DECODE. Else stay.
//  - DECODE: evaluate cond on flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V,
//    HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
//    Fail or operation=11 -> FETCH with no writes. Else -> EXEC.
//  - EXEC:
//    - DP: opALU=cmd; cin=1 for cmd 0010 (SUB), 0011 (RSB), 1010 (CMP), else 0; selOperaB=I.
//      If S=1 or cmd=10xx, flags<=alu_flags at the end of the cycle. Then -> WB.
//    - mem: opALU=0100 (ADD), selOperaB=1 -> MEM.
//    - branch: pc_wr=1, selPC=1. If link=1, also regWr=1, selAddWr=1, selDiWr=10. Then -> FETCH.
//  - MEM: mem_req=1, memWr=~L, opALU/selOperaB held as in EXEC. On mem_ready: load -> WB,
//    store -> FETCH.
//  - WB: regWr=1 except DP cmd 10xx (TST/TEQ/CMP/CMN). selDiWr=00 for DP, 01 for load.
//    selAddWr=0. Then -> FETCH.
//  - Latency (zero-wait memory): DP 4 cycles, load 5, store 4, branch 3, cond-fail 2.
//  - Wait counter: cleared on entry to FETCH/MEM, increments each cycle without mem_ready.
//    If MAX_WAIT!=0 and count reaches MAX_WAIT with no ready: bus_err=1 for one cycle,
//    no ir_wr/pc_wr/regWr, -> FETCH (counter cleared). mem_ready in the same cycle as the
//    limit wins over timeout.
//  - flags update only in EXEC. Condition evaluation in DECODE uses flags from prior instructions.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, flags=0000; cycle after release mem_req=1, state FETCH.
//  2. DP ADD cond=1110 op=00 opcodes=101001 (I=1, cmd=0100, S=1), alu_flags=0100, ready every cycle
//     -> ir_wr/pc_wr at c0, opALU=0100 at c2, flags=0100 after c2, regWr=1 selDiWr=00 at c3, FETCH at c4.
//  3. With Z=1: BEQ op=10 opcodes=010000 -> pc_wr=1 selPC=1 regWr=1 selAddWr=1 selDiWr=10 in EXEC.
//     BNE (cond=0001) -> back to FETCH after DECODE with no strobes.
//  4. Load (op=01, opcodes=100001) with mem_ready held low 3 cycles in MEM -> mem_req held, memWr=0,
//     regWr=1 selDiWr=01 exactly one cycle after ready.
//     Store (L=0) -> memWr=1 in MEM, no regWr.
//  5. MAX_WAIT=4, mem_ready stuck 0 in FETCH -> bus_err pulses once after 4 cycles, then mem_req reasserts.
//  6. CMP (cmd=1010, S=0) alu_flags=0110 -> cin=1, flags<=0110, no regWr in WB.
//     rst asserted during MEM -> memWr=0 immediately, FETCH after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, evaluates ARM condition codes
// against an internal NZCV register and bounds memory waits with a timeout.
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          condicion,
    input  logic [1:0]          operation,
    input  logic [OPCODE_W-1:0] opcodes,
    input  logic [3:0]          alu_flags,
    input  logic                mem_ready,
    output logic                ir_wr,
    output logic                pc_wr,
    output logic                selPC,
    output logic                regWr,
    output logic                selAddWr,
    output logic [ALUOP_W-1:0]  opALU,
    output logic                cin,
    output logic                selOperaB,
    output logic [1:0]          selDiWr,
    output logic                memWr,
    output logic                mem_req,
    output logic [3:0]          flags,
    output logic                bus_err
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic       imm_b, s_l, link, is_cmp, waiting, limit;
    logic [3:0] cmd;

    assign imm_b  = opcodes[5];
    assign cmd    = opcodes[4:1];
    assign s_l    = opcodes[0];
    assign link   = opcodes[4];
    assign is_cmp = (cmd[3:2] == 2'b10);

    // flags layout is {N, Z, C, V}
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = !cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cy && !z;
            4'b1001: cond_pass = !cy || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign limit   = (MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT));

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        selPC     = 1'b0;
        regWr     = 1'b0;
        selAddWr  = 1'b0;
        opALU     = '0;
        cin       = 1'b0;
        selOperaB = 1'b0;
        selDiWr   = 2'b00;
        memWr     = 1'b0;
        mem_req   = 1'b0;
        bus_err   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (limit) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (!cond_pass(condicion, flags_q) || (operation == 2'b11))
                    state_d = S_FETCH;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                case (operation)
                    2'b00: begin
                        opALU     = ALUOP_W'(cmd);
                        cin       = (cmd == 4'b0010) || (cmd == 4'b0011) || (cmd == 4'b1010);
                        selOperaB = imm_b;
                        if (s_l || is_cmp)
                            flags_d = alu_flags;
                        state_d   = S_WB;
                    end
                    2'b01: begin
                        opALU     = ALUOP_W'(4'b0100);
                        selOperaB = 1'b1;
                        state_d   = S_MEM;
                    end
                    2'b10: begin
                        pc_wr = 1'b1;
                        selPC = 1'b1;
                        if (link) begin
                            regWr    = 1'b1;
                            selAddWr = 1'b1;
                            selDiWr  = 2'b10;
                        end
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                memWr     = !s_l;
                opALU     = ALUOP_W'(4'b0100);
                selOperaB = 1'b1;
                if (mem_ready) begin
                    state_d = s_l ? S_WB : S_FETCH;
                end else if (limit) begin
                    bus_err = 1'b1;
                    memWr   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                if (operation == 2'b00) begin
                    regWr = !is_cmp;
                end else if (operation == 2'b01) begin
                    regWr   = 1'b1;
                    selDiWr = 2'b01;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // a timeout re-enters FETCH without a state change, so it clears the counter explicitly
        if ((state_d != state_q) || bus_err)
            cnt_d = '0;
        else if (waiting)
            cnt_d = cnt_q + CNT_W'(1);

        if (rst) begin
            ir_wr     = 1'b0;
            pc_wr     = 1'b0;
            selPC     = 1'b0;
            regWr     = 1'b0;
            selAddWr  = 1'b0;
            opALU     = '0;
            cin       = 1'b0;
            selOperaB = 1'b0;
            selDiWr   = 2'b00;
            memWr     = 1'b0;
            mem_req   = 1'b0;
            bus_err   = 1'b0;
        end
    end

    assign flags = rst ? 4'b0000 : flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench: each driven cycle pushes its expected outputs to a scoreboard that a
// negedge monitor pops and compares.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] condicion;
    logic [1:0] operation;
    logic [5:0] opcodes;
    logic [3:0] alu_flags;
    logic       mem_ready;
    logic       ir_wr, pc_wr, selPC, regWr, selAddWr, cin, selOperaB, memWr, mem_req, bus_err;
    logic [3:0] opALU;
    logic [1:0] selDiWr;
    logic [3:0] flags;

    multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(4), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .condicion(condicion), .operation(operation), .opcodes(opcodes),
        .alu_flags(alu_flags), .mem_ready(mem_ready), .ir_wr(ir_wr), .pc_wr(pc_wr), .selPC(selPC),
        .regWr(regWr), .selAddWr(selAddWr), .opALU(opALU), .cin(cin), .selOperaB(selOperaB),
        .selDiWr(selDiWr), .memWr(memWr), .mem_req(mem_req), .flags(flags), .bus_err(bus_err)
    );

    typedef struct {
        string       name;
        logic [15:0] outs;
        logic [3:0]  fl;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [15:0] act;
    int          n_assert = 0;
    int          n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ir_wr, pc_wr, selPC, regWr, selAddWr, opALU, cin, selOperaB, selDiWr, memWr, mem_req, bus_err}
    function automatic logic [15:0] mk(input logic ir, input logic pc, input logic sp,
                                       input logic rw, input logic sa, input logic [3:0] op,
                                       input logic ci, input logic sb, input logic [1:0] sd,
                                       input logic mw, input logic mr, input logic be);
        return {ir, pc, sp, rw, sa, op, ci, sb, sd, mw, mr, be};
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            act = {ir_wr, pc_wr, selPC, regWr, selAddWr, opALU, cin, selOperaB, selDiWr,
                   memWr, mem_req, bus_err};
            n_assert++;
            if (act !== cur.outs || flags !== cur.fl) begin
                n_fail++;
                $display("FAIL %s: got outs=%b flags=%b, expected outs=%b flags=%b",
                         cur.name, act, flags, cur.outs, cur.fl);
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] oc, input logic [3:0] af, input logic rd,
                       input logic [15:0] e, input logic [3:0] fl);
        exp_t x;
        rst = r; condicion = c; operation = o; opcodes = oc; alu_flags = af; mem_ready = rd;
        x.name = nm; x.outs = e; x.fl = fl;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] Z, FE, FW, EM;

    initial begin
        Z  = '0;
        FE = mk(1, 1, 0, 0, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 0);
        FW = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 0);
        EM = mk(0, 0, 0, 0, 0, 4'b0100, 0, 1, 2'b00, 0, 0, 0);
        rst = 1'b1; condicion = 4'hE; operation = 2'b00; opcodes = '0; alu_flags = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        cyc("rst_c0", 1, 4'hE, 2'b00, 6'b000000, 4'h0, 1, Z, 4'h0);
        cyc("rst_c1", 1, 4'hE, 2'b00, 6'b000000, 4'h0, 1, Z, 4'h0);

        // ADD S=1, immediate
        cyc("add_fetch",  0, 4'hE, 2'b00, 6'b101001, 4'b0100, 1, FE, 4'h0);
        cyc("add_decode", 0, 4'hE, 2'b00, 6'b101001, 4'b0100, 1, Z, 4'h0);
        cyc("add_exec",   0, 4'hE, 2'b00, 6'b101001, 4'b0100, 1,
            mk(0, 0, 0, 0, 0, 4'b0100, 0, 1, 2'b00, 0, 0, 0), 4'h0);
        cyc("add_wb",     0, 4'hE, 2'b00, 6'b101001, 4'b0100, 1,
            mk(0, 0, 0, 1, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 0), 4'b0100);

        // BL EQ with Z=1
        cyc("beq_fetch",  0, 4'h0, 2'b10, 6'b010000, 4'h0, 1, FE, 4'b0100);
        cyc("beq_decode", 0, 4'h0, 2'b10, 6'b010000, 4'h0, 1, Z, 4'b0100);
        cyc("beq_exec",   0, 4'h0, 2'b10, 6'b010000, 4'h0, 1,
            mk(0, 1, 1, 1, 1, 4'b0000, 0, 0, 2'b10, 0, 0, 0), 4'b0100);

        // BNE with Z=1 fails in DECODE
        cyc("bne_fetch",  0, 4'h1, 2'b10, 6'b010000, 4'h0, 1, FE, 4'b0100);
        cyc("bne_decode", 0, 4'h1, 2'b10, 6'b010000, 4'h0, 1, Z, 4'b0100);

        // Load with 3 wait cycles in MEM
        cyc("ld_fetch",   0, 4'hE, 2'b01, 6'b100001, 4'h0, 1, FE, 4'b0100);
        cyc("ld_decode",  0, 4'hE, 2'b01, 6'b100001, 4'h0, 1, Z, 4'b0100);
        cyc("ld_exec",    0, 4'hE, 2'b01, 6'b100001, 4'h0, 1, EM, 4'b0100);
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 0, 4'hE, 2'b01, 6'b100001, 4'h0, 0, EM | FW, 4'b0100);
        cyc("ld_mem_rdy", 0, 4'hE, 2'b01, 6'b100001, 4'h0, 1, EM | FW, 4'b0100);
        cyc("ld_wb",      0, 4'hE, 2'b01, 6'b100001, 4'h0, 1,
            mk(0, 0, 0, 1, 0, 4'b0000, 0, 0, 2'b01, 0, 0, 0), 4'b0100);

        // Store
        cyc("st_fetch",   0, 4'hE, 2'b01, 6'b100000, 4'h0, 1, FE, 4'b0100);
        cyc("st_decode",  0, 4'hE, 2'b01, 6'b100000, 4'h0, 1, Z, 4'b0100);
        cyc("st_exec",    0, 4'hE, 2'b01, 6'b100000, 4'h0, 1, EM, 4'b0100);
        cyc("st_mem",     0, 4'hE, 2'b01, 6'b100000, 4'h0, 1,
            mk(0, 0, 0, 0, 0, 4'b0100, 0, 1, 2'b00, 1, 1, 0), 4'b0100);

        // FETCH timeout at MAX_WAIT=4
        for (int i = 0; i < 4; i++)
            cyc("to_wait", 0, 4'hE, 2'b00, 6'b010100, 4'h0, 0, FW, 4'b0100);
        cyc("to_buserr", 0, 4'hE, 2'b00, 6'b010100, 4'h0, 0,
            mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 1), 4'b0100);

        // CMP, S=0: flags still update, no register write
        cyc("cmp_fetch",  0, 4'hE, 2'b00, 6'b010100, 4'b0110, 1, FE, 4'b0100);
        cyc("cmp_decode", 0, 4'hE, 2'b00, 6'b010100, 4'b0110, 1, Z, 4'b0100);
        cyc("cmp_exec",   0, 4'hE, 2'b00, 6'b010100, 4'b0110, 1,
            mk(0, 0, 0, 0, 0, 4'b1010, 1, 0, 2'b00, 0, 0, 0), 4'b0100);
        cyc("cmp_wb",     0, 4'hE, 2'b00, 6'b010100, 4'b0110, 1, Z, 4'b0110);

        // SUB, S=0: cin=1, flags untouched
        cyc("sub_fetch",  0, 4'hE, 2'b00, 6'b000100, 4'b1111, 1, FE, 4'b0110);
        cyc("sub_decode", 0, 4'hE, 2'b00, 6'b000100, 4'b1111, 1, Z, 4'b0110);
        cyc("sub_exec",   0, 4'hE, 2'b00, 6'b000100, 4'b1111, 1,
            mk(0, 0, 0, 0, 0, 4'b0010, 1, 0, 2'b00, 0, 0, 0), 4'b0110);
        cyc("sub_wb",     0, 4'hE, 2'b00, 6'b000100, 4'b1111, 1,
            mk(0, 0, 0, 1, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 0), 4'b0110);

        // Undefined operation behaves as NOP
        cyc("und_fetch",  0, 4'hE, 2'b11, 6'b111111, 4'h0, 1, FE, 4'b0110);
        cyc("und_decode", 0, 4'hE, 2'b11, 6'b111111, 4'h0, 1, Z, 4'b0110);

        // LT with N==V fails
        cyc("lt_fetch",   0, 4'hB, 2'b00, 6'b001001, 4'h0, 1, FE, 4'b0110);
        cyc("lt_decode",  0, 4'hB, 2'b00, 6'b001001, 4'h0, 1, Z, 4'b0110);

        // Reset during MEM of a store
        cyc("rs_fetch",   0, 4'hE, 2'b01, 6'b100000, 4'h0, 1, FE, 4'b0110);
        cyc("rs_decode",  0, 4'hE, 2'b01, 6'b100000, 4'h0, 1, Z, 4'b0110);
        cyc("rs_exec",    0, 4'hE, 2'b01, 6'b100000, 4'h0, 1, EM, 4'b0110);
        cyc("rs_mem",     0, 4'hE, 2'b01, 6'b100000, 4'h0, 0,
            mk(0, 0, 0, 0, 0, 4'b0100, 0, 1, 2'b00, 1, 1, 0), 4'b0110);
        cyc("rs_reset",   1, 4'hE, 2'b01, 6'b100000, 4'h0, 0, Z, 4'h0);
        cyc("rs_release", 0, 4'hE, 2'b01, 6'b100000, 4'h0, 0, FW, 4'h0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
